// File: rtl/music_sequencer.sv
// Multi-channel background-music player: each channel walks its own note ROM at a
// shared beat rate and drives a registered square-wave speaker bit.
module music_sequencer #(
  parameter int  NUM_CH   = 2,
  parameter int  ADDR_W   = 12,
  parameter int  BEAT_DIV = 520833,
  parameter real CLK_HZ   = 50.0e6
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     enable_i,
  input  logic [NUM_CH-1:0]        loop_i,
  input  logic [NUM_CH-1:0]        mute_i,
  output logic [NUM_CH*ADDR_W-1:0] rom_addr_o,
  input  logic [NUM_CH*8-1:0]      rom_data_i,
  output logic [NUM_CH-1:0]        speaker_o,
  output logic [NUM_CH-1:0]        done_o,
  output logic                     busy_o
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // FETCH | address presented, ROM latency cycle
  // LATCH | ROM byte valid: load note, loop or finish
  // PLAY  | tone running until the next beat tick
  // DONE  | one-shot channel reached its end marker
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int  BW   = (BEAT_DIV > 0) ? $clog2(BEAT_DIV + 1) : 1;
  localparam real SEMI = 1.0594630943592953;

  // Octave-0 half periods referenced to A2 = 110 Hz, so C2 lands on 65.4064 Hz.
  function automatic logic [18:0] hp0(input int n);
    real f;
    f = 110.0;
    for (int i = 9; i < n; i++) f = f * SEMI;
    for (int i = n; i < 9; i++) f = f / SEMI;
    return 19'($rtoi(CLK_HZ / (2.0 * f) + 0.5));
  endfunction

  localparam logic [18:0] HP_TAB [16] = '{
    hp0(0), hp0(1), hp0(2), hp0(3), hp0(4),  hp0(5),  hp0(6),  hp0(7),
    hp0(8), hp0(9), hp0(10), hp0(11), 19'd0, 19'd0, 19'd0, 19'd0
  };

  function automatic logic is_rest(input logic [7:0] nt);
    return (nt == 8'h00) || nt[7] || (nt[3:0] >= 4'd12);
  endfunction

  function automatic logic [18:0] note_hp(input logic [7:0] nt);
    return HP_TAB[nt[3:0]] >> nt[6:4];
  endfunction

  logic [BW-1:0]     beat_q, beat_d;
  logic              beat_tick;
  logic              busy;
  logic [2:0]        state_q  [NUM_CH];
  logic [2:0]        state_d  [NUM_CH];
  logic [ADDR_W-1:0] addr_q   [NUM_CH];
  logic [ADDR_W-1:0] addr_d   [NUM_CH];
  logic [7:0]        note_q   [NUM_CH];
  logic [7:0]        note_d   [NUM_CH];
  logic [18:0]       tone_q   [NUM_CH];
  logic [18:0]       tone_d   [NUM_CH];
  logic [NUM_CH-1:0] square_q, square_d;
  logic [NUM_CH-1:0] speaker_q, speaker_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [7:0]        rd;

  always_comb begin
    busy = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (state_q[c] != S_IDLE && state_q[c] != S_DONE) busy = 1'b1;

    beat_tick = enable_i && busy && (beat_q == BW'(BEAT_DIV));
    beat_d    = beat_q;
    if (start_i)               beat_d = '0;
    else if (enable_i && busy) beat_d = beat_tick ? '0 : beat_q + 1'b1;

    rd = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c]   = state_q[c];
      addr_d[c]    = addr_q[c];
      note_d[c]    = note_q[c];
      tone_d[c]    = tone_q[c];
      square_d[c]  = square_q[c];
      done_d[c]    = 1'b0;
      speaker_d[c] = square_q[c] & enable_i & ~mute_i[c];
      rd           = rom_data_i[c*8 +: 8];

      // The square is forced low whenever the channel leaves PLAY.
      if (start_i) begin
        addr_d[c]   = '0;
        state_d[c]  = S_FETCH;
        square_d[c] = 1'b0;
      end else if (enable_i) begin
        case (state_q[c])
          S_FETCH: state_d[c] = S_LATCH;
          S_LATCH: begin
            square_d[c] = 1'b0;
            if (rd == 8'hFF) begin
              if (loop_i[c]) begin
                addr_d[c]  = '0;
                state_d[c] = S_FETCH;
              end else begin
                note_d[c]  = 8'h00;
                done_d[c]  = 1'b1;
                state_d[c] = S_DONE;
              end
            end else begin
              note_d[c]  = rd;
              tone_d[c]  = note_hp(rd) - 19'd1;
              state_d[c] = S_PLAY;
            end
          end
          S_PLAY: begin
            if (beat_tick) begin
              addr_d[c]   = addr_q[c] + 1'b1;
              state_d[c]  = S_FETCH;
              square_d[c] = 1'b0;
            end else if (!is_rest(note_q[c])) begin
              if (tone_q[c] == 19'd0) begin
                square_d[c] = ~square_q[c];
                tone_d[c]   = note_hp(note_q[c]) - 19'd1;
              end else begin
                tone_d[c] = tone_q[c] - 19'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      beat_q    <= '0;
      square_q  <= '0;
      speaker_q <= '0;
      done_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= S_IDLE;
        addr_q[c]  <= '0;
        note_q[c]  <= 8'h00;
        tone_q[c]  <= '0;
      end
    end else begin
      beat_q    <= beat_d;
      square_q  <= square_d;
      speaker_q <= speaker_d;
      done_q    <= done_d;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        addr_q[c]  <= addr_d[c];
        note_q[c]  <= note_d[c];
        tone_q[c]  <= tone_d[c];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_addr
    assign rom_addr_o[g*ADDR_W +: ADDR_W] = addr_q[g];
  end

  assign speaker_o = speaker_q;
  assign done_o    = done_q;
  assign busy_o    = busy;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer: a per-cycle behavioural model plus literal checks.
module tb_music_sequencer;
  localparam int  NCH = 2;
  localparam int  AW  = 4;
  localparam int  BD  = 9;
  localparam real CLK = 1000.0;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           enable = 1'b1;
  logic [NCH-1:0] loop_v = '0;
  logic [NCH-1:0] mute = '0;
  logic [NCH*AW-1:0] rom_addr;
  logic [NCH*8-1:0]  rom_data;
  logic [NCH-1:0] speaker, done;
  logic           busy;
  logic [7:0]     rom [NCH][16];

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // model state: age 0 = address just issued, 1 = ROM byte due, >=2 = note playing
  int       m_addr [NCH];
  int       m_age  [NCH];
  int       m_t    [NCH];
  int       m_beat = 0;
  logic [7:0] m_note [NCH];
  bit       m_run  [NCH];
  bit       m_done [NCH];
  bit       m_spk  [NCH];

  always #5 clock = ~clock;

  music_sequencer #(.NUM_CH(NCH), .ADDR_W(AW), .BEAT_DIV(BD), .CLK_HZ(CLK)) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .enable_i(enable),
    .loop_i(loop_v), .mute_i(mute), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .speaker_o(speaker), .done_o(done), .busy_o(busy)
  );

  always @(posedge clock)
    for (int c = 0; c < NCH; c++) rom_data[c*8 +: 8] <= rom[c][rom_addr[c*AW +: AW]];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int mhp0(input real clk, input int n);
    return $rtoi(clk / (2.0 * 110.0 * $pow(2.0, real'(n - 9) / 12.0)) + 0.5);
  endfunction

  function automatic int mhp(input real clk, input logic [7:0] nt);
    return mhp0(clk, int'(nt[3:0])) >> nt[6:4];
  endfunction

  function automatic bit rest(input logic [7:0] nt);
    return (nt == 8'h00) || nt[7] || (nt[3:0] >= 4'd12);
  endfunction

  function automatic bit cur_sq(input int c);
    if (!m_run[c] || m_age[c] < 2 || rest(m_note[c])) return 1'b0;
    return ((m_t[c] / mhp(CLK, m_note[c])) % 2) == 1;
  endfunction

  task automatic model_step();
    bit bsy, tick;
    logic [7:0] d;
    bsy  = m_run[0] | m_run[1];
    tick = enable && bsy && (m_beat == BD);
    for (int c = 0; c < NCH; c++) begin
      m_spk[c]  = enable && !mute[c] && cur_sq(c);
      m_done[c] = 1'b0;
    end
    if (start) begin
      m_beat = 0;
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = 1'b1; m_addr[c] = 0; m_age[c] = 0;
      end
    end else if (enable) begin
      if (bsy) m_beat = tick ? 0 : m_beat + 1;
      for (int c = 0; c < NCH; c++) begin
        if (!m_run[c]) continue;
        if (m_age[c] == 0) m_age[c] = 1;
        else if (m_age[c] == 1) begin
          d = rom[c][m_addr[c]];
          if (d == 8'hFF) begin
            if (loop_v[c]) begin m_addr[c] = 0; m_age[c] = 0; end
            else begin m_run[c] = 1'b0; m_done[c] = 1'b1; end
          end else begin
            m_note[c] = d; m_t[c] = 0; m_age[c] = 2;
          end
        end else if (tick) begin
          m_addr[c] = (m_addr[c] + 1) % 16; m_age[c] = 0;
        end else m_t[c]++;
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_addr[c] = 0; m_age[c] = 0; m_t[c] = 0; m_note[c] = 8'h00;
      m_run[c] = 1'b0; m_done[c] = 1'b0; m_spk[c] = 1'b0;
    end
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_beat = 0;
        for (int c = 0; c < NCH; c++) begin
          m_addr[c] = 0; m_age[c] = 0; m_t[c] = 0; m_note[c] = 8'h00;
          m_run[c] = 1'b0; m_done[c] = 1'b0; m_spk[c] = 1'b0;
        end
      end else model_step();
    end
  end

  initial forever begin
    @(negedge clock);
    if (chk_on) begin
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("rom_addr%0d", c), int'(rom_addr[c*AW +: AW]), m_addr[c]);
        check($sformatf("speaker%0d", c), int'(speaker[c]), int'(m_spk[c]));
        check($sformatf("done%0d", c), int'(done[c]), int'(m_done[c]));
      end
      check("busy", int'(busy), int'(m_run[0] | m_run[1]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(2); reset = 1'b0; cyc(1);
  endtask

  task automatic fill(input int c, input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[c][i] = v;
  endtask

  int spk0, spk1, dn0;

  initial begin
    check("hp_C2_50M", mhp0(50.0e6, 0), 382226);
    check("hp_A2_50M", mhp0(50.0e6, 9), 227273);
    check("hp_A3_50M", mhp(50.0e6, 8'h19), 113636);
    check("hp_A2_1k", mhp(CLK, 8'h09), 5);
    check("hp_A4_1k", mhp(CLK, 8'h29), 1);
    fill(0, 8'h00); fill(1, 8'h00);
    chk_on = 1'b1;
    cyc(3); reset = 1'b0;

    cyc(30);
    check("idle_addr", int'(rom_addr), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_spk", int'(speaker), 0);

    // one-shot A2 then end marker; channel 1 ends immediately
    rom[0][0] = 8'h09; rom[0][1] = 8'hFF; rom[1][0] = 8'hFF;
    loop_v = 2'b00;
    pulse_start();
    spk0 = 0; dn0 = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      spk0 += int'(speaker[0]);
      dn0  += int'(done[0]);
      if (i == 12) begin
        check("oneshot_done_c12", int'(done[0]), 1);
        check("oneshot_busy_c12", int'(busy), 0);
      end
    end
    check("oneshot_spk_cycles", spk0, 3);
    check("oneshot_done_count", dn0, 1);
    check("oneshot_spk_end", int'(speaker[0]), 0);

    // looping song and address wrap on channel 1
    do_reset();
    fill(0, 8'h00);
    rom[0][0] = 8'h00; rom[0][1] = 8'h19; rom[0][2] = 8'hFF;
    for (int i = 0; i < 16; i++) rom[1][i] = (i % 3 == 0) ? 8'h2B : (i % 3 == 1) ? 8'h8C : 8'h1E;
    loop_v = 2'b11;
    pulse_start();
    cyc(10); check("loop_addr_c10", int'(rom_addr[3:0]), 1);
    cyc(10); check("loop_addr_c20", int'(rom_addr[3:0]), 2);
    cyc(3);  check("loop_addr_c23", int'(rom_addr[3:0]), 0);
    cyc(7);  check("loop_addr_c30", int'(rom_addr[3:0]), 1);
    check("ch1_addr_c30", int'(rom_addr[7:4]), 3);
    cyc(125); check("ch1_addr_c155", int'(rom_addr[7:4]), 15);
    cyc(5);   check("ch1_wrap_c160", int'(rom_addr[7:4]), 0);

    // pause mid-beat for 50 cycles, then a short pause across a LATCH
    pulse_start();
    cyc(5); enable = 1'b0;
    cyc(25); check("pause_spk", int'(speaker), 0);
    cyc(25); enable = 1'b1;
    cyc(4); check("pause_addr_c59", int'(rom_addr[3:0]), 0);
    cyc(1); check("pause_addr_c60", int'(rom_addr[3:0]), 1);
    cyc(1); enable = 1'b0;
    cyc(7); enable = 1'b1;
    cyc(20);

    // restart while playing with channel 0 muted
    do_reset();
    fill(0, 8'h1B); fill(1, 8'h29);
    loop_v = 2'b11; mute = 2'b00;
    pulse_start();
    cyc(25);
    mute = 2'b01;
    pulse_start();
    check("restart_addr", int'(rom_addr), 0);
    spk0 = 0; spk1 = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      spk0 += int'(speaker[0]);
      spk1 += int'(speaker[1]);
    end
    check("muted_spk0", spk0, 0);
    check("spk1_highs", spk1, 16);

    // asynchronous reset between clock edges
    cyc(3);
    #2 reset = 1'b1;
    #1;
    check("async_addr", int'(rom_addr), 0);
    check("async_busy", int'(busy), 0);
    check("async_spk", int'(speaker), 0);
    @(negedge clock);
    cyc(2); reset = 1'b0;
    cyc(10);
    check("post_reset_idle", int'(busy), 0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
